uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-bit UART receiver, mid-bit sampling, optional even parity
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx #(
  parameter int CLKS_PER_BIT = 521
) (
  input  logic       rx_clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LP_HALF = 16'((CLKS_PER_BIT - 1) / 2);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_rx_prev;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_frame_err;
  logic        w_rx_s;
  logic        w_fall;

  // Synchronizer flops idle high so reset never looks like a start bit
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx_in;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  assign w_rx_s = r_sync2;
  assign w_fall = r_rx_prev & ~w_rx_s;

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;
`endif

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          if (w_fall) r_state <= S_START;
        end
        S_START: begin
          // A start bit that is gone by mid-bit is treated as a glitch
          if (r_cnt == LP_HALF) begin
            r_cnt   <= '0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (r_cnt == LP_LAST) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == LP_LAST) begin
            r_cnt     <= '0;
            r_par_bit <= w_rx_s;
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (r_cnt == LP_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            if (w_rx_s) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= r_par_bit ^ (^r_shift);
`endif
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign rx_busy   = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at CLKS_PER_BIT=16
module tb_uart_rx;
  localparam int CPB = 16;

  logic       rx_clk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rx_in  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .rx_clk(rx_clk), .rst_n(rst_n), .rx_in(rx_in), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_err(frame_err),
    .parity_err(parity_err)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic       is_ferr;
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t    exp_q[$];
  int      n_tests = 0;
  int      n_fail  = 0;
  longint  cyc = 0;
  longint  valid_cyc[$];

  always @(posedge rx_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected event
  always @(negedge rx_clk) begin
    if (rst_n && (rx_valid || frame_err || parity_err)) begin
      exp_t e;
      if (rx_valid) valid_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, rx_valid, frame_err, parity_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.is_ferr) begin
          check("ferr_pulse", {30'd0, frame_err, rx_valid}, 32'h2);
          check("ferr_no_perr", {31'd0, parity_err}, 32'd0);
        end else begin
          check("valid_pulse", {30'd0, rx_valid, frame_err}, 32'h2);
          check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge rx_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par) rx_in = 1'b1;
`endif
    drive_bit(stop);
  endtask

  task automatic expect_valid(input logic [7:0] d, input logic perr);
    exp_t e;
    e.is_ferr = 1'b0; e.data = d; e.perr = perr;
    exp_q.push_back(e);
  endtask

  task automatic expect_ferr();
    exp_t e;
    e.is_ferr = 1'b1; e.data = 8'h00; e.perr = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge rx_clk);
      n++;
    end
    check(name, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge rx_clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_outputs", {28'd0, rx_valid, rx_busy, frame_err, parity_err}, 32'd0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge rx_clk);

    // 0xA5 plain frame
    expect_valid(8'hA5, 1'b0);
    send_frame(8'hA5, ^8'hA5, 1'b1);
    drive_bit(1'b1);
    drain("a5_drain");

    // Short low glitch is rejected after a brief START
    rx_in = 1'b0;
    repeat (4) @(negedge rx_clk);
    rx_in = 1'b1;
    repeat (3) @(negedge rx_clk);
    check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
    repeat (20) @(negedge rx_clk);
    check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
    check("glitch_rx_data", {24'd0, rx_data}, 32'hA5);

    // Bad stop bit: frame error, data retained
    expect_ferr();
    send_frame(8'h3C, ^8'h3C, 1'b0);
    drain("ferr_drain");
    check("ferr_rx_data", {24'd0, rx_data}, 32'hA5);
    drive_bit(1'b1);
    drive_bit(1'b1);

    // Back-to-back 0x00 then 0xFF
    valid_cyc.delete();
    expect_valid(8'h00, 1'b0);
    expect_valid(8'hFF, 1'b0);
    send_frame(8'h00, ^8'h00, 1'b1);
    send_frame(8'hFF, ^8'hFF, 1'b1);
    drive_bit(1'b1);
    drain("b2b_drain");
    check("b2b_count", valid_cyc.size(), 32'd2);
    if (valid_cyc.size() == 2)
      check("b2b_spacing", 32'(valid_cyc[1] - valid_cyc[0]), 32'(CPB * `ifdef UART_RX_PARITY_EN 11 `else 10 `endif));

    // Reset during data bit 4 of 0x55
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
    rx_in = 1'b1;
    repeat (CPB / 2) @(negedge rx_clk);
    check("pre_reset_busy", {31'd0, rx_busy}, 32'd1);
    rst_n = 1'b0;
    repeat (2) @(negedge rx_clk);
    check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
    check("midreset_outputs", {28'd0, rx_valid, rx_busy, frame_err, parity_err}, 32'd0);
    rst_n = 1'b1;
    repeat (3 * CPB) @(negedge rx_clk);
    check("post_reset_busy", {31'd0, rx_busy}, 32'd0);
    check("post_reset_rx_data", {24'd0, rx_data}, 32'd0);
    expect_valid(8'h81, 1'b0);
    send_frame(8'h81, ^8'h81, 1'b1);
    drive_bit(1'b1);
    drain("x81_drain");
    check("x81_rx_data", {24'd0, rx_data}, 32'h81);

`ifdef UART_RX_PARITY_EN
    expect_valid(8'h03, 1'b1);
    send_frame(8'h03, 1'b1, 1'b1);
    drive_bit(1'b1);
    drain("par_bad_drain");
    expect_valid(8'h03, 1'b0);
    send_frame(8'h03, 1'b0, 1'b1);
    drive_bit(1'b1);
    drain("par_good_drain");
`endif

    repeat (4 * CPB) @(negedge rx_clk);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
